// File: rtl/card_draw_arbiter.sv
// Round-robin card draw arbiter between player and dealer sharing one RNG.
// Rejects invalid or exhausted ranks and tracks the cards left in the shoe.
module card_draw_arbiter #(
  parameter int DECKS = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       shuffle,
  input  logic       req_player,
  input  logic       req_dealer,
  input  logic [3:0] rng_card,
  output logic       ack_player,
  output logic       ack_dealer,
  output logic [3:0] card_rank,
  output logic [3:0] card_value,
  output logic [7:0] cards_left,
  output logic       deck_empty,
  output logic       busy,
  output logic [1:0] o_dbg_state
);

  localparam logic [7:0] TOTAL_CARDS = 8'(52 * DECKS);
  localparam logic [4:0] MAX_PER_RANK = 5'(4 * DECKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAW    = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_owner_dealer;
  logic       r_prio_dealer;
  logic [4:0] r_cnt [13];
  logic [7:0] r_cards_left;
  logic [3:0] r_card_rank;
  logic [3:0] r_card_value;

  logic [4:0] w_cnt_sel;
  logic       w_rank_ok;
  logic       w_accept;
  logic       w_grant_dealer;
  logic [3:0] w_value;

  // Dealt count of the rank currently on rng_card (zero for illegal codes).
  always_comb begin
    w_cnt_sel = '0;
    for (int i = 0; i < 13; i++) begin
      if (rng_card == 4'(i + 1)) w_cnt_sel = r_cnt[i];
    end
  end

  assign w_rank_ok      = (rng_card >= 4'd1) && (rng_card <= 4'd13) && (w_cnt_sel < MAX_PER_RANK);
  assign w_accept       = (r_state == S_DRAW) && w_rank_ok;
  assign w_grant_dealer = req_dealer && (!req_player || r_prio_dealer);
  assign w_value        = (rng_card >= 4'd10) ? 4'd10 : rng_card;

  // Handshake: req is a level request sampled in IDLE; the granted side gets a
  // single-cycle ack in DELIVER with card_rank/card_value valid. A req still
  // high in the following IDLE cycle is treated as a new request.
  always_comb begin
    w_next_state = r_state;
    ack_player   = 1'b0;
    ack_dealer   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!deck_empty && (req_player || req_dealer)) w_next_state = S_DRAW;
      end
      S_DRAW: begin
        if (w_accept) w_next_state = S_DELIVER;
      end
      S_DELIVER: begin
        ack_player   = !r_owner_dealer;
        ack_dealer   = r_owner_dealer;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_owner_dealer <= 1'b0;
      r_prio_dealer  <= 1'b0;
      r_cards_left   <= TOTAL_CARDS;
      r_card_rank    <= '0;
      r_card_value   <= '0;
      for (int i = 0; i < 13; i++) r_cnt[i] <= '0;
    end else if (shuffle) begin
      // Rank/value and the round-robin pointer survive a shuffle.
      r_state      <= S_IDLE;
      r_cards_left <= TOTAL_CARDS;
      for (int i = 0; i < 13; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_next_state == S_DRAW) r_owner_dealer <= w_grant_dealer;
      if (w_accept) begin
        r_card_rank   <= rng_card;
        r_card_value  <= w_value;
        r_cards_left  <= r_cards_left - 8'd1;
        r_prio_dealer <= !r_owner_dealer;
        for (int i = 0; i < 13; i++) begin
          if (rng_card == 4'(i + 1)) r_cnt[i] <= r_cnt[i] + 5'd1;
        end
      end
    end
  end

  assign card_rank   = r_card_rank;
  assign card_value  = r_card_value;
  assign cards_left  = r_cards_left;
  assign deck_empty  = (r_cards_left == 8'd0);
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_card_draw_arbiter.sv
// Self-checking bench for card_draw_arbiter: a shoe model predicts every
// delivered card into a queue that the ack monitor pops and compares.
module tb_card_draw_arbiter;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       shuffle = 1'b0;
  logic       req_player = 1'b0;
  logic       req_dealer = 1'b0;
  logic [3:0] rng_card = 4'd0;
  logic       ack_player, ack_dealer, deck_empty, busy;
  logic [3:0] card_rank, card_value;
  logic [7:0] cards_left;
  logic [1:0] dbg_state;

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  card_draw_arbiter #(.DECKS(1)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .shuffle    (shuffle),
    .req_player (req_player),
    .req_dealer (req_dealer),
    .rng_card   (rng_card),
    .ack_player (ack_player),
    .ack_dealer (ack_dealer),
    .card_rank  (card_rank),
    .card_value (card_value),
    .cards_left (cards_left),
    .deck_empty (deck_empty),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] exp_q[$];          // {dealer, rank, value}
  int         model_cnt[14];
  int         exp_left;
  bit         model_prio_dealer;
  logic [3:0] model_rank;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] val_of(input logic [3:0] r);
    return (r >= 4'd10) ? 4'd10 : r;
  endfunction

  task automatic model_clear_shoe();
    for (int i = 0; i < 14; i++) model_cnt[i] = 0;
    exp_left = 52;
  endtask

  task automatic model_push(input bit dealer, input logic [3:0] r);
    exp_q.push_back({dealer, r, val_of(r)});
    model_cnt[r]++;
    exp_left--;
    model_prio_dealer = !dealer;
    model_rank = r;
  endtask

  always @(negedge clk) begin
    if (!reset && (ack_player || ack_dealer)) begin
      if (exp_q.size() == 0) begin
        check_eq("ack_unexpected", 32'({ack_dealer, ack_player}), 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check_eq("ack_player", 32'(ack_player), 32'(!e[8]));
        check_eq("ack_dealer", 32'(ack_dealer), 32'(e[8]));
        check_eq("card_rank", 32'(card_rank), 32'(e[7:4]));
        check_eq("card_value", 32'(card_value), 32'(e[3:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; shuffle = 1'b0; req_player = 1'b0; req_dealer = 1'b0; rng_card = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear_shoe();
    model_prio_dealer = 1'b0;
    model_rank = 4'd0;
    exp_q.delete();
  endtask

  task automatic wait_ack(input int budget, input int t0, output int lat, output bit got);
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (ack_player || ack_dealer) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic no_ack_window(input int n, input string tag);
    int acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack_player || ack_dealer) acks++;
    end
    check_eq(tag, 32'(acks), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic single_draw(input bit dealer, input logic [3:0] r);
    int t0, lat;
    bit got;
    if (dealer) req_dealer = 1'b1; else req_player = 1'b1;
    rng_card = r;
    t0 = cyc;
    model_push(dealer, r);
    @(posedge clk); #1;
    req_player = 1'b0; req_dealer = 1'b0;
    wait_ack(10, t0, lat, got);
    if (got) check_eq("draw_latency", 32'(lat), 32'd2);
    check_eq("cards_left", 32'(cards_left), 32'(exp_left));
  endtask

  task automatic both_draw(input logic [3:0] r);
    int t0, lat;
    bit got, first;
    first = model_prio_dealer;
    req_player = 1'b1; req_dealer = 1'b1; rng_card = r;
    t0 = cyc;
    model_push(first, r);
    model_push(!first, r);
    wait_ack(10, t0, lat, got);
    if (got) check_eq("arb_first_latency", 32'(lat), 32'd2);
    if (first) req_dealer = 1'b0; else req_player = 1'b0;
    t0 = cyc;
    wait_ack(10, t0, lat, got);
    if (got) check_eq("arb_second_latency", 32'(lat), 32'd2);
    req_player = 1'b0; req_dealer = 1'b0;
    check_eq("arb_cards_left", 32'(cards_left), 32'(exp_left));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, lat;
    bit got;
    logic [3:0] r;

    do_reset();
    check_eq("rst_ack_player", 32'(ack_player), 32'd0);
    check_eq("rst_ack_dealer", 32'(ack_dealer), 32'd0);
    check_eq("rst_card_rank", 32'(card_rank), 32'd0);
    check_eq("rst_card_value", 32'(card_value), 32'd0);
    check_eq("rst_cards_left", 32'(cards_left), 32'd52);
    check_eq("rst_deck_empty", 32'(deck_empty), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // Basic player draw
    single_draw(1'b0, 4'd7);

    // Arbitration from reset, then pointer alternation
    do_reset();
    both_draw(4'd12);
    single_draw(1'b0, 4'd4);
    both_draw(4'd12);

    // Ace / face mapping
    single_draw(1'b0, 4'd1);
    single_draw(1'b1, 4'd10);
    single_draw(1'b0, 4'd11);
    single_draw(1'b1, 4'd13);

    // Shuffle during DRAW aborts the draw
    req_player = 1'b1; rng_card = 4'd9;
    @(posedge clk); #1;
    req_player = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd1);
    check_eq("abort_in_draw", 32'(dbg_state), 32'd1);
    shuffle = 1'b1;
    @(posedge clk); #1;
    shuffle = 1'b0;
    model_clear_shoe();
    check_eq("shuf_state", 32'(dbg_state), 32'd0);
    check_eq("shuf_busy", 32'(busy), 32'd0);
    check_eq("shuf_cards_left", 32'(cards_left), 32'd52);
    check_eq("shuf_rank_kept", 32'(card_rank), 32'(model_rank));
    no_ack_window(6, "shuf_no_ack");

    // Reset during DRAW aborts and clears the rank
    req_dealer = 1'b1; rng_card = 4'd9;
    @(posedge clk); #1;
    req_dealer = 1'b0;
    check_eq("rabort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear_shoe();
    model_prio_dealer = 1'b0;
    model_rank = 4'd0;
    check_eq("rabort_rank", 32'(card_rank), 32'd0);
    check_eq("rabort_value", 32'(card_value), 32'd0);
    check_eq("rabort_cards_left", 32'(cards_left), 32'd52);
    check_eq("rabort_state", 32'(dbg_state), 32'd0);
    no_ack_window(6, "rabort_no_ack");

    // Rejection: exhaust aces, then resample through 1,0,15 to 3
    for (int i = 0; i < 4; i++) single_draw(1'b0, 4'd1);
    req_player = 1'b1; rng_card = 4'd1;
    t0 = cyc;
    model_push(1'b0, 4'd3);
    @(posedge clk); #1; req_player = 1'b0; rng_card = 4'd1;
    @(posedge clk); #1; rng_card = 4'd0;
    @(posedge clk); #1; rng_card = 4'd15;
    @(posedge clk); #1; rng_card = 4'd3;
    wait_ack(10, t0, lat, got);
    if (got) check_eq("reject_latency", 32'(lat), 32'd5);
    check_eq("reject_cards_left", 32'(cards_left), 32'(exp_left));

    // Exhaustion: deal the whole shoe with random legal ranks
    do_reset();
    while (exp_left > 0) begin
      do r = 4'($urandom_range(1, 13)); while (model_cnt[r] >= 4);
      single_draw(1'($urandom_range(0, 1)), r);
    end
    check_eq("empty_cards_left", 32'(cards_left), 32'd0);
    check_eq("empty_flag", 32'(deck_empty), 32'd1);
    req_player = 1'b1; rng_card = 4'd5;
    no_ack_window(20, "empty_no_ack");
    check_eq("empty_busy", 32'(busy), 32'd0);

    // Shuffle with the request pending: shuffle wins, then the request is served
    shuffle = 1'b1;
    t0 = cyc + 1;
    model_clear_shoe();
    model_push(1'b0, 4'd5);
    @(posedge clk); #1;
    shuffle = 1'b0;
    check_eq("refill_cards_left", 32'(cards_left), 32'd52);
    check_eq("refill_empty", 32'(deck_empty), 32'd0);
    check_eq("refill_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_player = 1'b0;
    wait_ack(10, t0, lat, got);
    if (got) check_eq("refill_latency", 32'(lat), 32'd2);
    check_eq("refill_after", 32'(cards_left), 32'(exp_left));

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
